// File: rtl/yutorina_opfetch_if.sv
// yutorina operand-fetch bundle: decode inputs, register-file read port,
// EX/MEM forwarding taps, stall/flush control and the registered ID/EX outputs.
interface yutorina_opfetch_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
);
    // decoded instruction
    logic              in_valid;
    logic [WORD_W-1:0] in_pc;
    logic [ADDR_W-1:0] in_ra_addr;
    logic [ADDR_W-1:0] in_rb_addr;
    logic              in_ra_use;
    logic              in_rb_use;
    logic [WORD_W-1:0] in_imm;
    logic              in_imm_sel;
    logic [ADDR_W-1:0] in_dst_addr;
    logic              in_dst_we;
    logic              in_is_load;
    // register file read port
    logic [ADDR_W-1:0] gpr_r_addr1;
    logic [ADDR_W-1:0] gpr_r_addr2;
    logic [WORD_W-1:0] gpr_r_data1;
    logic [WORD_W-1:0] gpr_r_data2;
    // EX stage tap
    logic              ex_valid;
    logic              ex_dst_we;
    logic              ex_is_load;
    logic [ADDR_W-1:0] ex_dst_addr;
    logic [WORD_W-1:0] ex_result;
    // MEM stage tap
    logic              mem_valid;
    logic              mem_dst_we;
    logic [ADDR_W-1:0] mem_dst_addr;
    logic [WORD_W-1:0] mem_result;
    // control
    logic              stall;
    logic              flush;
    logic              load_hazard;
    // ID/EX register
    logic              id_valid;
    logic              id_dst_we;
    logic              id_is_load;
    logic [WORD_W-1:0] id_pc;
    logic [WORD_W-1:0] id_op_a;
    logic [WORD_W-1:0] id_op_b;
    logic [ADDR_W-1:0] id_ra_addr;
    logic [ADDR_W-1:0] id_dst_addr;
    logic [CNT_W-1:0]  hazard_cnt;

    // master: the surrounding pipeline (decode, regfile, EX, MEM)
    modport master (
        output in_valid, in_pc, in_ra_addr, in_rb_addr,
        output in_ra_use, in_rb_use, in_imm, in_imm_sel,
        output in_dst_addr, in_dst_we, in_is_load,
        output gpr_r_data1, gpr_r_data2,
        output ex_valid, ex_dst_we, ex_is_load, ex_dst_addr, ex_result,
        output mem_valid, mem_dst_we, mem_dst_addr, mem_result,
        output stall, flush,
        input  gpr_r_addr1, gpr_r_addr2, load_hazard,
        input  id_valid, id_dst_we, id_is_load, id_pc,
        input  id_op_a, id_op_b, id_ra_addr, id_dst_addr, hazard_cnt
    );

    // slave: the operand-fetch stage
    modport slave (
        input  in_valid, in_pc, in_ra_addr, in_rb_addr,
        input  in_ra_use, in_rb_use, in_imm, in_imm_sel,
        input  in_dst_addr, in_dst_we, in_is_load,
        input  gpr_r_data1, gpr_r_data2,
        input  ex_valid, ex_dst_we, ex_is_load, ex_dst_addr, ex_result,
        input  mem_valid, mem_dst_we, mem_dst_addr, mem_result,
        input  stall, flush,
        output gpr_r_addr1, gpr_r_addr2, load_hazard,
        output id_valid, id_dst_we, id_is_load, id_pc,
        output id_op_a, id_op_b, id_ra_addr, id_dst_addr, hazard_cnt
    );
endinterface

// File: rtl/yutorina_opfetch.sv
// yutorina operand-fetch stage: drives regfile read addresses, forwards
// EX/MEM results (EX first), detects load-use hazards and holds the ID/EX
// register with stall/flush; counts load-hazard bubbles (saturating).
// Ports: clk, rst (async, active-high), bus (yutorina_opfetch_if.slave).
module yutorina_opfetch #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
) (
    input logic               clk,
    input logic               rst,
    yutorina_opfetch_if.slave bus
);
    // forwarding hits
    logic ex_fwd_ok;
    logic mem_fwd_ok;
    logic ex_hit_a;
    logic ex_hit_b;
    logic mem_hit_a;
    logic mem_hit_b;
    logic [WORD_W-1:0] raw_a;
    logic [WORD_W-1:0] raw_b;
    logic [WORD_W-1:0] op_a;
    logic [WORD_W-1:0] op_b;

    // load-use detection
    logic ex_load_ok;
    logic hz_a;
    logic hz_b;
    logic hazard;

    // ID/EX register
    logic              valid_q,    valid_d;
    logic              dst_we_q,   dst_we_d;
    logic              is_load_q,  is_load_d;
    logic [WORD_W-1:0] pc_q,       pc_d;
    logic [WORD_W-1:0] op_a_q,     op_a_d;
    logic [WORD_W-1:0] op_b_q,     op_b_d;
    logic [ADDR_W-1:0] ra_addr_q,  ra_addr_d;
    logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    assign bus.gpr_r_addr1 = bus.in_ra_addr;
    assign bus.gpr_r_addr2 = bus.in_rb_addr;

    // a load in EX has no data yet, so it never forwards
    assign ex_fwd_ok  = bus.ex_valid & bus.ex_dst_we & ~bus.ex_is_load;
    assign mem_fwd_ok = bus.mem_valid & bus.mem_dst_we;

    assign ex_hit_a = ex_fwd_ok
                    & (bus.ex_dst_addr == bus.in_ra_addr)
                    & (bus.in_ra_addr != '0);
    assign ex_hit_b = ex_fwd_ok
                    & (bus.ex_dst_addr == bus.in_rb_addr)
                    & (bus.in_rb_addr != '0);
    assign mem_hit_a = mem_fwd_ok
                     & (bus.mem_dst_addr == bus.in_ra_addr)
                     & (bus.in_ra_addr != '0);
    assign mem_hit_b = mem_fwd_ok
                     & (bus.mem_dst_addr == bus.in_rb_addr)
                     & (bus.in_rb_addr != '0);

    always_comb begin
        raw_a = bus.gpr_r_data1;
        if (ex_hit_a) begin
            raw_a = bus.ex_result;
        end else if (mem_hit_a) begin
            raw_a = bus.mem_result;
        end
    end

    always_comb begin
        raw_b = bus.gpr_r_data2;
        if (ex_hit_b) begin
            raw_b = bus.ex_result;
        end else if (mem_hit_b) begin
            raw_b = bus.mem_result;
        end
    end

    assign op_a = raw_a;
    assign op_b = bus.in_imm_sel ? bus.in_imm : raw_b;

    assign ex_load_ok = bus.ex_valid & bus.ex_dst_we & bus.ex_is_load
                      & (bus.ex_dst_addr != '0);
    assign hz_a = bus.in_ra_use
                & (bus.in_ra_addr == bus.ex_dst_addr);
    // an immediate replaces rb, so rb cannot create a hazard then
    assign hz_b = bus.in_rb_use & ~bus.in_imm_sel
                & (bus.in_rb_addr == bus.ex_dst_addr);
    assign hazard = bus.in_valid & ex_load_ok & (hz_a | hz_b);

    assign bus.load_hazard = hazard;

    always_comb begin
        valid_d    = valid_q;
        dst_we_d   = dst_we_q;
        is_load_d  = is_load_q;
        pc_d       = pc_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        ra_addr_d  = ra_addr_q;
        dst_addr_d = dst_addr_q;
        cnt_d      = cnt_q;

        if (bus.flush) begin
            valid_d   = 1'b0;
            dst_we_d  = 1'b0;
            is_load_d = 1'b0;
        end else if (bus.stall) begin
            valid_d = valid_q;
        end else if (hazard) begin
            valid_d   = 1'b0;
            dst_we_d  = 1'b0;
            is_load_d = 1'b0;
        end else begin
            valid_d    = bus.in_valid;
            dst_we_d   = bus.in_dst_we & bus.in_valid;
            is_load_d  = bus.in_is_load & bus.in_valid;
            pc_d       = bus.in_pc;
            op_a_d     = op_a;
            op_b_d     = op_b;
            ra_addr_d  = bus.in_ra_addr;
            dst_addr_d = bus.in_dst_addr;
        end

        // one bubble is actually issued only when the stage advances
        if (hazard & ~bus.stall & ~bus.flush & ~(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            dst_we_q   <= 1'b0;
            is_load_q  <= 1'b0;
            pc_q       <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            ra_addr_q  <= '0;
            dst_addr_q <= '0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            dst_we_q   <= dst_we_d;
            is_load_q  <= is_load_d;
            pc_q       <= pc_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            ra_addr_q  <= ra_addr_d;
            dst_addr_q <= dst_addr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.id_valid    = valid_q;
    assign bus.id_dst_we   = dst_we_q;
    assign bus.id_is_load  = is_load_q;
    assign bus.id_pc       = pc_q;
    assign bus.id_op_a     = op_a_q;
    assign bus.id_op_b     = op_b_q;
    assign bus.id_ra_addr  = ra_addr_q;
    assign bus.id_dst_addr = dst_addr_q;
    assign bus.hazard_cnt  = cnt_q;
endmodule

// File: tb/tb_yutorina_opfetch.sv
// Bench for yutorina_opfetch: directed scenarios plus random traffic
// checked against a behavioural model of the operand-fetch rules.
module tb_yutorina_opfetch;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // model of the ID/EX register
    logic              m_valid;
    logic              m_we;
    logic              m_ld;
    logic [WORD_W-1:0] m_pc;
    logic [WORD_W-1:0] m_a;
    logic [WORD_W-1:0] m_b;
    logic [ADDR_W-1:0] m_ra;
    logic [ADDR_W-1:0] m_dst;
    logic [CNT_W-1:0]  m_cnt;

    yutorina_opfetch_if #(
        .WORD_W(WORD_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) bus ();

    yutorina_opfetch #(
        .WORD_W(WORD_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Value register x holds as seen by this stage: start from the
    // register file and let younger producers overwrite it (MEM, then EX).
    function automatic logic [WORD_W-1:0] view(input logic [ADDR_W-1:0] x,
                                               input logic [WORD_W-1:0] rf);
        logic [WORD_W-1:0] v;
        v = rf;
        if (x == 0) return rf;
        if (bus.mem_valid && bus.mem_dst_we && bus.mem_dst_addr == x)
            v = bus.mem_result;
        if (bus.ex_valid && bus.ex_dst_we && !bus.ex_is_load
            && bus.ex_dst_addr == x)
            v = bus.ex_result;
        return v;
    endfunction

    function automatic logic model_hz();
        logic reads_a;
        logic reads_b;
        if (!(bus.in_valid && bus.ex_valid && bus.ex_dst_we
              && bus.ex_is_load && bus.ex_dst_addr != 0))
            return 1'b0;
        reads_a = bus.in_ra_use && bus.in_ra_addr == bus.ex_dst_addr;
        reads_b = bus.in_rb_use && !bus.in_imm_sel
               && bus.in_rb_addr == bus.ex_dst_addr;
        return reads_a || reads_b;
    endfunction

    task automatic clr_in();
        bus.in_valid     = 0;
        bus.in_pc        = 0;
        bus.in_ra_addr   = 0;
        bus.in_rb_addr   = 0;
        bus.in_ra_use    = 0;
        bus.in_rb_use    = 0;
        bus.in_imm       = 0;
        bus.in_imm_sel   = 0;
        bus.in_dst_addr  = 0;
        bus.in_dst_we    = 0;
        bus.in_is_load   = 0;
        bus.gpr_r_data1  = 0;
        bus.gpr_r_data2  = 0;
        bus.ex_valid     = 0;
        bus.ex_dst_we    = 0;
        bus.ex_is_load   = 0;
        bus.ex_dst_addr  = 0;
        bus.ex_result    = 0;
        bus.mem_valid    = 0;
        bus.mem_dst_we   = 0;
        bus.mem_dst_addr = 0;
        bus.mem_result   = 0;
        bus.stall        = 0;
        bus.flush        = 0;
    endtask

    task automatic model_reset();
        m_valid = 0; m_we = 0; m_ld = 0;
        m_pc = 0; m_a = 0; m_b = 0;
        m_ra = 0; m_dst = 0; m_cnt = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, bus.id_valid, 0);
        chk({tag, "_we"}, bus.id_dst_we, 0);
        chk({tag, "_ld"}, bus.id_is_load, 0);
        chk({tag, "_pc"}, bus.id_pc, 0);
        chk({tag, "_opa"}, bus.id_op_a, 0);
        chk({tag, "_opb"}, bus.id_op_b, 0);
        chk({tag, "_ra"}, bus.id_ra_addr, 0);
        chk({tag, "_dst"}, bus.id_dst_addr, 0);
        chk({tag, "_cnt"}, bus.hazard_cnt, 0);
    endtask

    // One clock: check combinational outputs, advance the model,
    // cross the edge and compare the registered outputs.
    task automatic step(input bit full);
        logic hz;
        logic [WORD_W-1:0] ea;
        logic [WORD_W-1:0] eb;
        #1;
        hz = model_hz();
        ea = view(bus.in_ra_addr, bus.gpr_r_data1);
        eb = bus.in_imm_sel ? bus.in_imm
                            : view(bus.in_rb_addr, bus.gpr_r_data2);
        if (full) begin
            chk("rd_addr1", bus.gpr_r_addr1, bus.in_ra_addr);
            chk("rd_addr2", bus.gpr_r_addr2, bus.in_rb_addr);
        end
        chk("load_hazard", bus.load_hazard, hz);
        if (bus.flush) begin
            m_valid = 0; m_we = 0; m_ld = 0;
        end else if (bus.stall) begin
            m_valid = m_valid;
        end else if (hz) begin
            m_valid = 0; m_we = 0; m_ld = 0;
        end else begin
            m_valid = bus.in_valid;
            m_we    = bus.in_valid && bus.in_dst_we;
            m_ld    = bus.in_valid && bus.in_is_load;
            m_pc    = bus.in_pc;
            m_a     = ea;
            m_b     = eb;
            m_ra    = bus.in_ra_addr;
            m_dst   = bus.in_dst_addr;
        end
        if (hz && !bus.stall && !bus.flush && m_cnt != {CNT_W{1'b1}})
            m_cnt = m_cnt + 1;
        @(posedge clk);
        #1;
        chk("id_valid", bus.id_valid, m_valid);
        chk("hazard_cnt", bus.hazard_cnt, m_cnt);
        if (full) begin
            chk("id_dst_we", bus.id_dst_we, m_we);
            chk("id_is_load", bus.id_is_load, m_ld);
            if (m_valid) begin
                chk("id_pc", bus.id_pc, m_pc);
                chk("id_op_a", bus.id_op_a, m_a);
                chk("id_op_b", bus.id_op_b, m_b);
                chk("id_ra_addr", bus.id_ra_addr, m_ra);
                chk("id_dst_addr", bus.id_dst_addr, m_dst);
            end
        end
    endtask

    task automatic set_ex(input logic ld, input logic [ADDR_W-1:0] a,
                          input logic [WORD_W-1:0] r);
        bus.ex_valid = 1; bus.ex_dst_we = 1; bus.ex_is_load = ld;
        bus.ex_dst_addr = a; bus.ex_result = r;
    endtask

    task automatic set_mem(input logic [ADDR_W-1:0] a,
                           input logic [WORD_W-1:0] r);
        bus.mem_valid = 1; bus.mem_dst_we = 1;
        bus.mem_dst_addr = a; bus.mem_result = r;
    endtask

    initial begin
        logic [WORD_W-1:0] held_pc;
        checks = 0;
        errors = 0;
        rst = 1;
        clr_in();
        model_reset();
        #1;
        chk_zero("reset");
        #1 rst = 0;

        // forwarding priority EX > MEM > regfile
        bus.in_valid = 1; bus.in_pc = 32'h100;
        bus.in_ra_addr = 3; bus.in_ra_use = 1;
        bus.in_dst_addr = 7; bus.in_dst_we = 1;
        set_ex(0, 3, 32'h11);
        set_mem(3, 32'h22);
        bus.gpr_r_data1 = 32'h33;
        step(1);
        chk("fwd_ex", bus.id_op_a, 32'h11);
        bus.ex_valid = 0;
        step(1);
        chk("fwd_mem", bus.id_op_a, 32'h22);
        bus.mem_valid = 0;
        step(1);
        chk("fwd_rf", bus.id_op_a, 32'h33);

        // r0 never forwards
        bus.in_ra_addr = 0;
        set_ex(0, 0, 32'hFFFF);
        set_mem(0, 32'hFFFF);
        bus.gpr_r_data1 = 0;
        step(1);
        chk("r0_opa", bus.id_op_a, 0);

        // load-use: one bubble, then MEM forwards the load data
        clr_in();
        bus.in_valid = 1; bus.in_pc = 32'h200;
        bus.in_rb_addr = 5; bus.in_rb_use = 1;
        set_ex(1, 5, 32'hDEAD);
        bus.gpr_r_data2 = 32'h5555;
        step(1);
        chk("lu_bubble", bus.id_valid, 0);
        chk("lu_cnt", bus.hazard_cnt, 1);
        bus.ex_valid = 0;
        set_mem(5, 32'hABCD);
        step(1);
        chk("lu_opb", bus.id_op_b, 32'hABCD);
        chk("lu_valid", bus.id_valid, 1);

        // immediate operand B hides the load dependency
        clr_in();
        bus.in_valid = 1; bus.in_pc = 32'h300;
        bus.in_rb_addr = 5; bus.in_rb_use = 1;
        bus.in_imm_sel = 1; bus.in_imm = 32'h10;
        set_ex(1, 5, 32'hDEAD);
        step(1);
        chk("imm_opb", bus.id_op_b, 32'h10);
        chk("imm_cnt", bus.hazard_cnt, 1);

        // stall holds, flush beats stall
        held_pc = bus.id_pc;
        clr_in();
        bus.in_valid = 1; bus.in_pc = 32'h400;
        bus.stall = 1;
        for (int i = 0; i < 3; i++) step(1);
        chk("stall_pc", bus.id_pc, held_pc);
        chk("stall_valid", bus.id_valid, 1);
        bus.flush = 1;
        step(1);
        chk("flush_valid", bus.id_valid, 0);

        // asynchronous reset mid-run with id_valid=1, hazard_cnt=5
        rst = 1;
        #1 rst = 0;
        model_reset();
        clr_in();
        bus.in_valid = 1; bus.in_ra_use = 1; bus.in_ra_addr = 9;
        set_ex(1, 9, 0);
        for (int i = 0; i < 5; i++) step(1);
        clr_in();
        bus.in_valid = 1; bus.in_pc = 32'h500; bus.in_dst_we = 1;
        bus.in_dst_addr = 4; bus.gpr_r_data1 = 32'h77;
        step(1);
        chk("pre_rst_valid", bus.id_valid, 1);
        chk("pre_rst_cnt", bus.hazard_cnt, 5);
        #2 rst = 1;
        #1;
        model_reset();
        chk_zero("midrst");
        #2 rst = 0;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bus.in_valid     = ($urandom_range(0, 3) != 0);
            bus.in_pc        = $urandom;
            bus.in_ra_addr   = ADDR_W'($urandom_range(0, 3));
            bus.in_rb_addr   = ADDR_W'($urandom_range(0, 3));
            bus.in_ra_use    = $urandom_range(0, 1);
            bus.in_rb_use    = $urandom_range(0, 1);
            bus.in_imm       = $urandom;
            bus.in_imm_sel   = ($urandom_range(0, 3) == 0);
            bus.in_dst_addr  = ADDR_W'($urandom_range(0, 31));
            bus.in_dst_we    = $urandom_range(0, 1);
            bus.in_is_load   = $urandom_range(0, 1);
            bus.gpr_r_data1  = $urandom;
            bus.gpr_r_data2  = $urandom;
            bus.ex_valid     = $urandom_range(0, 1);
            bus.ex_dst_we    = $urandom_range(0, 1);
            bus.ex_is_load   = $urandom_range(0, 1);
            bus.ex_dst_addr  = ADDR_W'($urandom_range(0, 3));
            bus.ex_result    = $urandom;
            bus.mem_valid    = $urandom_range(0, 1);
            bus.mem_dst_we   = $urandom_range(0, 1);
            bus.mem_dst_addr = ADDR_W'($urandom_range(0, 3));
            bus.mem_result   = $urandom;
            bus.stall        = ($urandom_range(0, 7) == 0);
            bus.flush        = ($urandom_range(0, 9) == 0);
            step(1);
        end

        // saturation of the hazard counter
        clr_in();
        bus.in_valid = 1; bus.in_ra_use = 1; bus.in_ra_addr = 2;
        set_ex(1, 2, 0);
        for (int i = 0; i < (1 << CNT_W) + 3; i++) step(0);
        chk("cnt_sat", bus.hazard_cnt, {CNT_W{1'b1}});

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/yutorina_opfetch.md
Name: yutorina_opfetch

Overview:
- Operand-fetch stage of the yutorina pipeline, sitting between instruction decode and the register file's read ports on one side and the execute stage on the other.
- Drives both GPR read addresses from the decoded source fields.
- Selects each operand by priority: EX-stage result, then MEM-stage result, then register file. Write-back bypass is handled inside the register file.
- Detects load-use hazards and registers operands and control into the ID/EX pipeline register, with stall and flush support.

Parameters:
- WORD_W, 32, data word width.
- ADDR_W, 5, GPR address width (32 registers; register 0 is hardwired zero).
- CNT_W, 16, width of the load-hazard event counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  decoded instruction present this cycle.
- in_pc  in  WORD_W  PC of the decoded instruction.
- in_ra_addr / in_rb_addr  in  ADDR_W each  source register addresses.
- in_ra_use / in_rb_use  in  1 each  the source is actually read.
- in_imm  in  WORD_W  sign-extended immediate.
- in_imm_sel  in  1  operand B takes in_imm instead of the rb value.
- in_dst_addr  in  ADDR_W  destination register.
- in_dst_we  in  1  instruction writes in_dst_addr.
- in_is_load  in  1  instruction is a load.
- gpr_r_addr1 / gpr_r_addr2  out  ADDR_W each  register file read addresses.
- gpr_r_data1 / gpr_r_data2  in  WORD_W each  register file read data (combinational).
- ex_valid, ex_dst_we, ex_is_load  in  1 each  status of the instruction in EX.
- ex_dst_addr  in  ADDR_W  EX destination.
- ex_result  in  WORD_W  EX ALU result.
- mem_valid, mem_dst_we  in  1 each  status of the instruction in MEM.
- mem_dst_addr  in  ADDR_W  MEM destination.
- mem_result  in  WORD_W  MEM result (load data or passed ALU value).
- stall  in  1  downstream hold request.
- flush  in  1  discard the instruction in this stage.
- load_hazard  out  1  combinational; upstream must hold its instruction.
- id_valid, id_dst_we, id_is_load  out  1 each  registered.
- id_pc, id_op_a, id_op_b  out  WORD_W each  registered.
- id_ra_addr, id_dst_addr  out  ADDR_W each  registered.
- hazard_cnt  out  CNT_W  load-hazard bubble count, saturating.

Behaviour:
- gpr_r_addr1 = in_ra_addr and gpr_r_addr2 = in_rb_addr, combinationally and always, regardless of in_valid.
- Forward-hit conditions:
  - ex_hit(x) = ex_valid & ex_dst_we & ~ex_is_load & ex_dst_addr==x & x!=0.
  - mem_hit(x) = mem_valid & mem_dst_we & mem_dst_addr==x & x!=0.
- Raw operand value = ex_result if ex_hit, else mem_result if mem_hit, else gpr data. EX wins over MEM when both hit.
- op_a = raw(ra). op_b = in_imm if in_imm_sel, else raw(rb).
- load_hazard = in_valid & ex_valid & ex_dst_we & ex_is_load & ex_dst_addr!=0 & ((in_ra_use & in_ra_addr==ex_dst_addr) | (in_rb_use & ~in_imm_sel & in_rb_addr==ex_dst_addr)).
- Pipeline register update on each rising clk; the first matching rule applies:
  1. rst: id_valid, id_dst_we, id_is_load = 0; id_pc, id_op_a, id_op_b = 0; id_ra_addr, id_dst_addr = 0; hazard_cnt = 0. Takes effect immediately (asynchronous), including mid-operation.
  2. flush: id_valid, id_dst_we, id_is_load <= 0; data fields are don't-care but hold their value. Flush overrides stall.
  3. stall: all id_* hold.
  4. load_hazard: insert a bubble. id_valid, id_dst_we, id_is_load <= 0.
  5. Otherwise: load all id_* from the current inputs and selected operands. id_valid <= in_valid; id_dst_we <= in_dst_we & in_valid; id_is_load <= in_is_load & in_valid.
- hazard_cnt increments by 1 when load_hazard & ~stall & ~flush & ~rst. It saturates at all-ones and never wraps.
- An instruction with id_valid=0 never asserts id_dst_we.
- Latency: one cycle from inputs to id_* outputs.
- A load-use pair costs exactly one bubble. The next cycle the load is in MEM, and its data arrives via mem_result.

Test Plan:
- Reset mid-run with id_valid=1 and hazard_cnt=5 -> all id_* and hazard_cnt read 0 before the next clk edge.
- ra=3; ex writes r3=0x11 (ALU); mem writes r3=0x22; gpr r3=0x33 -> next cycle id_op_a=0x11. Drop EX -> 0x22. Drop MEM -> 0x33.
- ra=0; ex and mem both target r0 with 0xFFFF; gpr returns 0 -> id_op_a=0, no forwarding.
- EX is a load to r5; in rb=r5, rb_use=1, imm_sel=0 -> load_hazard=1, id_valid=0 next cycle, hazard_cnt+1. Following cycle with the load in MEM (0xABCD) -> id_op_b=0xABCD, id_valid=1.
- Same pair but imm_sel=1, imm=0x10 -> load_hazard=0, id_op_b=0x10.
- stall=1 for 3 cycles -> id_* unchanged. Assert flush with stall=1 -> id_valid=0. Hold hazard 2^CNT_W+3 cycles -> hazard_cnt=all-ones.
